// File: rtl/uart_pkg.sv
// Shared UART types: transmit launch FSM states and the serializer data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } tx_queue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic circular-buffer FIFO with push/pop, clear, occupancy count, full/empty.
// Latency: a pushed entry is visible on head/count the cycle after the push.
// Backpressure: pushes while full are ignored unless a pop happens in the same cycle.
//
// Ports: clk, rst (async active-high), clear (sync, wins over push/pop),
//        push/push_data, pop, head (entry at rd_ptr), count (0..DEPTH), full, empty.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to fill.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries below count are ever read out.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tx_queue.sv
// UART transmit byte queue: buffers register-bank writes, launches one byte at a time.
// Latency: first transmit_o 2 cycles after wr_en_i into an empty queue; next 2 cycles after done_i.
// Backpressure: none upstream; a push into a full queue is dropped and flagged on overrun_o.
//
// Ports: clk_i, rst_i (async active-high); wr_en_i/wr_data_i push side;
//        full_o, empty_o, level_o status from registered count; overrun_o one-cycle drop pulse
//        (registered, appears the cycle after the dropped push);
//        transmit_o/dr_o/busy_o/done_i serializer handshake.
// Optional: define TX_QUEUE_FLUSH_EN to add flush_i (sync clear, in-flight frame still completes).
module tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = UART_DATA_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
`ifdef TX_QUEUE_FLUSH_EN
    input  logic                   flush_i,
`endif
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overrun_o,
    output logic                   busy_o,
    output logic                   transmit_o,
    output logic [WIDTH-1:0]       dr_o,
    input  logic                   done_i
);

    tx_queue_state_t  state;
    tx_queue_state_t  state_nxt;
    logic             flush;
    logic             pop;
    logic             push;
    logic             drop;
    logic [WIDTH-1:0] head;

`ifdef TX_QUEUE_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Pop only from IDLE and only on the registered count, so a byte pushed
    // this cycle cannot be launched before next cycle. Flush suppresses it so
    // the FSM does not launch a byte that is being discarded.
    assign pop  = (state == IDLE) && !empty_o && !flush;
    assign push = wr_en_i && !flush && (!full_o || pop);
    assign drop = wr_en_i && !flush && full_o && !pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (flush),
        .push      (push),
        .push_data (wr_data_i),
        .pop       (pop),
        .head      (head),
        .count     (level_o),
        .full      (full_o),
        .empty     (empty_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            dr_o      <= '0;
            overrun_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            overrun_o <= drop;
            if (pop) dr_o <= head;
        end
    end

    always_comb begin
        state_nxt  = state;
        transmit_o = 1'b0;
        busy_o     = 1'b0;
        case (state)
            IDLE: begin
                if (pop) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                transmit_o = 1'b1;
                busy_o     = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy_o = 1'b1;
                if (done_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_queue.sv
module tb_tx_queue;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             wr_en_i = 1'b0;
    logic [WIDTH-1:0] wr_data_i = '0;
    logic             done_i = 1'b0;
    logic             full_o;
    logic             empty_o;
    logic [3:0]       level_o;
    logic             overrun_o;
    logic             busy_o;
    logic             transmit_o;
    logic [WIDTH-1:0] dr_o;

    tx_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
`ifdef TX_QUEUE_FLUSH_EN
        .flush_i    (flush_i),
`endif
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .level_o    (level_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o),
        .transmit_o (transmit_o),
        .dr_o       (dr_o),
        .done_i     (done_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] tx_q[$];
    int         tx_cyc[$];
    int         done_cyc[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Serializer-side monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (transmit_o) begin
            tx_q.push_back(dr_o);
            tx_cyc.push_back(cyc);
        end
        if (done_i) done_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    task automatic wait_tx_count(input int n, input int limit);
        int t = 0;
        while (tx_q.size() < n && t < limit) begin
            tick();
            t++;
        end
        if (tx_q.size() < n) check("tx_timeout", tx_q.size(), n);
    endtask

    task automatic clear_log();
        tx_q.delete();
        tx_cyc.delete();
        done_cyc.delete();
    endtask

    logic [7:0] exp_ovf [10];
    logic       early_ovr;

    initial begin
        // ---------------- reset values while held in reset
        tick();
        tick();
        check("rst_empty", empty_o, 1);
        check("rst_level", level_o, 0);
        check("rst_full", full_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_tx", transmit_o, 0);
        check("rst_dr", dr_o, 0);
        check("rst_ovr", overrun_o, 0);
        rst_i = 1'b0;
        tick();

        // ---------------- single byte
        clear_log();
        push(8'hA5);
        check("sb_level1", level_o, 1);
        check("sb_tx_c1", transmit_o, 0);
        tick();
        check("sb_tx_c2", transmit_o, 1);
        check("sb_dr", dr_o, 8'hA5);
        check("sb_busy_launch", busy_o, 1);
        check("sb_level0", level_o, 0);
        tick();
        check("sb_tx_pulse", transmit_o, 0);
        repeat (4) tick();
        check("sb_busy_wait", busy_o, 1);
        check("sb_dr_held", dr_o, 8'hA5);
        pulse_done();
        check("sb_busy_done", busy_o, 0);
        check("sb_empty", empty_o, 1);

        // done_i outside WAIT is ignored
        pulse_done();
        repeat (3) tick();
        check("stray_done_busy", busy_o, 0);
        check("stray_done_tx", tx_q.size(), 1);

        // ---------------- back-to-back with 100-cycle frames
        clear_log();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        for (int k = 0; k < 3; k++) begin
            wait_tx_count(k + 1, 20);
            repeat (98) tick();
            pulse_done();
        end
        repeat (5) tick();
        check("b2b_count", tx_q.size(), 3);
        if (tx_q.size() == 3 && done_cyc.size() == 3) begin
            check("b2b_d0", tx_q[0], 8'h11);
            check("b2b_d1", tx_q[1], 8'h22);
            check("b2b_d2", tx_q[2], 8'h33);
            check("b2b_gap1", tx_cyc[1] - done_cyc[0], 2);
            check("b2b_gap2", tx_cyc[2] - done_cyc[1], 2);
        end
        check("b2b_idle", busy_o, 0);

        // ---------------- overflow: 10 pushes, done held low
        clear_log();
        early_ovr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_ovf[i] = 8'hB0 + 8'(i);
            if (overrun_o) early_ovr = 1'b1;
            push(8'hB0 + 8'(i));
        end
        exp_ovf[9] = 8'hC0;   // B9 dropped; C0 pushed later fills the last slot
        check("ovf_no_early", early_ovr, 0);
        check("ovf_pulse", overrun_o, 1);
        check("ovf_full", full_o, 1);
        check("ovf_level", level_o, 8);
        tick();
        check("ovf_pulse_end", overrun_o, 0);
        check("ovf_inflight", tx_q.size(), 1);

        // ---------------- push while full with simultaneous pop
        pulse_done();                 // WAIT -> IDLE, count still 8
        check("pf_level_pre", level_o, 8);
        push(8'hC0);                  // pop and push in the same cycle
        check("pf_level", level_o, 8);
        check("pf_full", full_o, 1);
        check("pf_no_ovr", overrun_o, 0);
        check("pf_tx", transmit_o, 1);
        check("pf_dr", dr_o, 8'hB1);
        for (int j = 0; j < 9; j++) begin
            repeat (3) tick();
            pulse_done();
        end
        repeat (4) tick();
        check("ovf_tx_count", tx_q.size(), 10);
        if (tx_q.size() == 10)
            for (int i = 0; i < 10; i++) check($sformatf("ovf_order%0d", i), tx_q[i], exp_ovf[i]);
        check("ovf_drained", level_o, 0);

`ifdef TX_QUEUE_FLUSH_EN
        // ---------------- flush with 5 queued and one in flight
        clear_log();
        for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
        check("fl_level_pre", level_o, 5);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_level", level_o, 0);
        check("fl_empty", empty_o, 1);
        check("fl_busy", busy_o, 1);
        repeat (2) tick();
        pulse_done();
        check("fl_done_busy", busy_o, 0);
        repeat (6) tick();
        check("fl_no_more_tx", tx_q.size(), 1);
`endif

        // ---------------- asynchronous reset mid-frame
        push(8'hE1);
        push(8'hE2);
        check("ar_tx_pre", transmit_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("ar_tx", transmit_o, 0);
        check("ar_busy", busy_o, 0);
        check("ar_dr", dr_o, 0);
        check("ar_level", level_o, 0);
        check("ar_empty", empty_o, 1);
        check("ar_full", full_o, 0);
        check("ar_ovr", overrun_o, 0);
        tick();
        rst_i = 1'b0;
        repeat (3) tick();
        check("ar_stay_idle", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
